// File: rtl/sram_access_arbiter.sv
// Purpose: two-port arbiter that splits 32-bit word accesses into two 16-bit SRAM half-word transactions.
// Latency: ready rises 2*SRAM_WAIT+1 cycles after the grant edge (IDLE->LO), i.e. in the DONE cycle.
// Backpressure: readyN=0 while port N requests and is not in DONE; optional macro SRAM_ARB_ROUND_ROBIN_EN.
module sram_access_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SRAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd0,
    input  logic        wr0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ready0,
    input  logic        rd1,
    input  logic        wr1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ready1,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int            CW   = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SRAM_WAIT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          phase_end;
    logic          req0, req1, grant1;

    // latched grant
    logic          owner;
    logic          is_wr;
    logic [16:0]   word;
    logic [31:0]   wdata;

    logic [31:0]   eff0, eff1;
    logic          dq_oe;
    logic [15:0]   dq_out;
    logic          unused_eff;

    assign eff0       = addr0 - BASE_ADDR;
    assign eff1       = addr1 - BASE_ADDR;
    // Byte-lane bits and bits above the 512 KB window are intentionally dropped (wrap-around).
    assign unused_eff = &{1'b0, eff0[31:19], eff0[1:0], eff1[31:19], eff1[1:0]};

    assign req0      = rd0 | wr0;
    assign req1      = rd1 | wr1;
    assign phase_end = (cnt == LAST);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_served;   // 1 = port 1 was granted most recently

    // Tie goes to the port that was not granted last.
    always_comb begin
        grant1 = req1 & ~(req0 & last_served);
    end

    // Remember who won the latest grant.
    always_ff @(posedge clk) begin
        if (!rst)
            last_served <= 1'b1;
        else if (state == IDLE && (req0 || req1))
            last_served <= grant1;
    end
`else
    // Fixed priority: port 0 wins every tie.
    always_comb begin
        grant1 = req1 & ~req0;
    end
`endif

    // State and phase-counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state plus all SRAM strobes, decoded from the current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            end
            LO, HI: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_WE_N = ~is_wr;
                SRAM_OE_N = is_wr;
                SRAM_ADDR = {word, (state == HI)};
                dq_oe     = is_wr;
                dq_out    = (state == HI) ? wdata[31:16] : wdata[15:0];
                if (phase_end) begin
                    state_nxt = (state == HI) ? DONE : HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign ready0 = ~req0 | (state == DONE && owner == 1'b0);
    assign ready1 = ~req1 | (state == DONE && owner == 1'b1);

    // Latch owner, operation, word address and write data on the edge leaving IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner <= 1'b0;
            is_wr <= 1'b0;
            word  <= '0;
            wdata <= '0;
        end else if (state == IDLE && (req0 || req1)) begin
            owner <= grant1;
            is_wr <= grant1 ? wr1 : wr0;
            word  <= grant1 ? eff1[18:2] : eff0[18:2];
            wdata <= grant1 ? wdata1 : wdata0;
        end
    end

    // Capture read data into the owner's register at the last cycle of each phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if ((state == LO || state == HI) && !is_wr && phase_end) begin
            if (owner) begin
                if (state == HI) rdata1[31:16] <= SRAM_DQ;
                else             rdata1[15:0]  <= SRAM_DQ;
            end else begin
                if (state == HI) rdata0[31:16] <= SRAM_DQ;
                else             rdata0[15:0]  <= SRAM_DQ;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Purpose: directed self-checking bench for sram_access_arbiter with a behavioural 16-bit SRAM.
// Latency: ready expected on the 5th edge counted from the grant edge (inclusive) at SRAM_WAIT=2.
// Backpressure: requests are held until ready, then dropped in the DONE cycle.
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, ce_n, we_n, oe_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:63];

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .clk(clk), .rst(rst),
        .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ready0(ready0),
        .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ready1(ready1),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
    );

    // Behavioural SRAM: synchronous write capture, combinational read drive.
    always @(posedge clk)
        if (!ce_n && !we_n) mem[sram_addr[5:0]] <= sram_dq;
    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[5:0]] : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on one port; lat = edges until ready (grant edge counts as 1).
    task automatic txn(input bit port, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd);
        lat = 0;
        if (port) begin rd1 = ~w; wr1 = w; addr1 = a; wdata1 = d; end
        else      begin rd0 = ~w; wr0 = w; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 30; i++) begin
            step();
            lat++;
            if (port ? ready1 : ready0) break;
        end
        rd = port ? rdata1 : rdata0;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        step();
    endtask

    // Wait with both ports held until either becomes ready.
    task automatic wait_any(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            lat++;
            if (ready0 || ready1) break;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;

        rst = 1'b0;
        rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'd1024; wdata0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0;       wdata1 = '0;
        step();
        step();
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        check("rst_ready1", {31'd0, ready1}, 32'd1);
        check("rst_strobes", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1f);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);

        rd0 = 1'b0;
        rst = 1'b1;
        step();

        // Port 0 write, phase by phase.
        wr0 = 1'b1; addr0 = 32'd1024; wdata0 = 32'hDEADBEEF;
        step();
        check("wr_lo1_strobes", {29'd0, ce_n, we_n, oe_n}, 32'b001);
        check("wr_lo1_addr", {14'd0, sram_addr}, 32'd0);
        check("wr_lo1_dq", {16'd0, sram_dq}, 32'hBEEF);
        check("wr_lo1_ready0", {31'd0, ready0}, 32'd0);
        step();
        check("wr_lo2_we", {31'd0, we_n}, 32'd0);
        check("wr_lo2_ready0", {31'd0, ready0}, 32'd0);
        step();
        check("wr_hi1_we", {31'd0, we_n}, 32'd0);
        check("wr_hi1_addr", {14'd0, sram_addr}, 32'd1);
        check("wr_hi1_dq", {16'd0, sram_dq}, 32'hDEAD);
        step();
        check("wr_hi2_we", {31'd0, we_n}, 32'd0);
        check("wr_hi2_ready0", {31'd0, ready0}, 32'd0);
        step();
        check("wr_done_ready0", {31'd0, ready0}, 32'd1);
        check("wr_done_strobes", {29'd0, ce_n, we_n, oe_n}, 32'b111);
        wr0 = 1'b0;
        step();
        check("wr_idle_ready0", {31'd0, ready0}, 32'd1);
        check("mem0", {16'd0, mem[0]}, 32'hBEEF);
        check("mem1", {16'd0, mem[1]}, 32'hDEAD);

        // Port 0 read back.
        txn(1'b0, 1'b0, 32'd1024, 32'd0, lat, rd);
        check("rd0_lat", lat, 32'd5);
        check("rd0_data", rd, 32'hDEADBEEF);

        // Port 1 write.
        txn(1'b1, 1'b1, 32'd1028, 32'h12345678, lat, rd);
        check("wr1_lat", lat, 32'd5);
        check("mem2", {16'd0, mem[2]}, 32'h5678);
        check("mem3", {16'd0, mem[3]}, 32'h1234);

        // Wrap-around above 512 KB and ignored byte-lane bits.
        txn(1'b1, 1'b0, 32'd1024 + 32'd524288 + 32'd7, 32'd0, lat, rd);
        check("wrap_data", rd, 32'h12345678);

        // Simultaneous held reads: first tie always goes to port 0.
        rd0 = 1'b1; addr0 = 32'd1028;
        rd1 = 1'b1; addr1 = 32'd1024;
        wait_any(lat);
        check("tie1_lat", lat, 32'd5);
        check("tie1_ready0", {31'd0, ready0}, 32'd1);
        check("tie1_ready1", {31'd0, ready1}, 32'd0);
        check("tie1_rdata0", rdata0, 32'h12345678);
        step();
        check("tie1_idle_ready0", {31'd0, ready0}, 32'd0);
        wait_any(lat);
        check("tie2_lat", lat, 32'd5);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        check("tie2_ready1", {31'd0, ready1}, 32'd1);
        check("tie2_ready0", {31'd0, ready0}, 32'd0);
        check("tie2_rdata1", rdata1, 32'hDEADBEEF);
`else
        check("tie2_ready0", {31'd0, ready0}, 32'd1);
        check("tie2_ready1", {31'd0, ready1}, 32'd0);
        check("tie2_rdata0", rdata0, 32'h12345678);
`endif
        rd0 = 1'b0; rd1 = 1'b0;
        step();

        // Reset during the high phase of a write.
        wr0 = 1'b1; addr0 = 32'd1032; wdata0 = 32'hAAAA5555;
        step();
        step();
        step();
        check("mid_hi_addr", {14'd0, sram_addr}, 32'd5);
        rst = 1'b0;
        step();
        check("mid_rst_strobes", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1f);
        check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
        check("mid_rst_ready0", {31'd0, ready0}, 32'd0);
        wr0 = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_mem4", {16'd0, mem[4]}, 32'h5555);
        txn(1'b0, 1'b0, 32'd1024, 32'd0, lat, rd);
        check("post_rst_lat", lat, 32'd5);
        check("post_rst_data", rd, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
